i2c_master_byte_engine: RTL

- Single-byte I2C master transaction engine. It sits directly downstream of the I2C clock prescaler and consumes that block's scl_clk and sda_clk outputs.
- On a start request it performs one complete transfer on the bus: START, 7-bit address plus R/W, address ACK, one data byte, data ACK/NACK, STOP.
- Runs entirely in the sys_clk domain. The prescaler clocks are sampled as ordinary signals, never used as clocks.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_phase_tick.sv | 34 +++
 rtl/i2c_master_byte_engine.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master engine.
package i2c_pkg;

   localparam int I2C_ADDR_W = 7;
   localparam int I2C_DATA_W = 8;

   localparam logic I2C_RW_WRITE = 1'b0;
   localparam logic I2C_RW_READ  = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START_WAIT,
      ADDR,
      ADDR_ACK,
      DATA,
      DATA_ACK,
      STOP_LOW,
      STOP
   } i2c_state_t;

endpackage

// File: rtl/i2c_phase_tick.sv
// Turns the prescaler's scl_clk/sda_clk levels into single-cycle sys_clk strobes.
module i2c_phase_tick (
   input  logic sys_clk,
   input  logic reset,
   input  logic scl_clk,
   input  logic sda_clk,
   output logic mid_high,
   output logic mid_low,
   output logic scl_fall,
   output logic scl_rise
);

   logic sda_clk_q;
   logic scl_clk_q;
   logic tick;

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         sda_clk_q <= 1'b0;
         scl_clk_q <= 1'b1;
      end else begin
         sda_clk_q <= sda_clk;
         scl_clk_q <= scl_clk;
      end
   end

   // Any sda_clk edge lands in the middle of an SCL phase; scl_clk tells which one.
   assign tick     = sda_clk ^ sda_clk_q;
   assign mid_high = tick & scl_clk;
   assign mid_low  = tick & ~scl_clk;
   assign scl_fall = scl_clk_q & ~scl_clk;
   assign scl_rise = ~scl_clk_q & scl_clk;

endmodule

// File: rtl/i2c_master_byte_engine.sv
// One complete I2C transfer per start pulse: START, addr+R/W, ACK, one byte, ACK/NACK, STOP.
module i2c_master_byte_engine
   import i2c_pkg::*;
#(
   parameter int ADDR_W = I2C_ADDR_W,
   parameter int DATA_W = I2C_DATA_W
) (
   input  logic              sys_clk,
   input  logic              reset,
   input  logic              scl_clk,
   input  logic              sda_clk,
   input  logic              start,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              sda_in,
   output logic              scl_out,
   output logic              sda_oe,
   output logic              busy,
   output logic              done,
   output logic              ack_err,
   output logic [DATA_W-1:0] rdata,
   output i2c_state_t        dbg_state
);

   localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int CNT_W = $clog2(MAX_W + 1);

   i2c_state_t        state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [ADDR_W:0]   addr_sr;
   logic [DATA_W-1:0] data_sr;
   logic              rw_q;
   logic              scl_en;
   logic              mid_high;
   logic              mid_low;
   logic              scl_fall;
   logic              scl_rise;

   i2c_phase_tick u_phase_tick (
      .sys_clk  (sys_clk),
      .reset    (reset),
      .scl_clk  (scl_clk),
      .sda_clk  (sda_clk),
      .mid_high (mid_high),
      .mid_low  (mid_low),
      .scl_fall (scl_fall),
      .scl_rise (scl_rise)
   );

   // With scl_en cleared by reset, SCL is released without waiting for a clock edge.
   assign scl_out   = scl_en ? scl_clk : 1'b1;
   assign dbg_state = state;

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         bit_cnt <= '0;
         addr_sr <= '0;
         data_sr <= '0;
         rw_q    <= I2C_RW_WRITE;
         scl_en  <= 1'b0;
         sda_oe  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         ack_err <= 1'b0;
         rdata   <= '0;
      end else begin
         done <= 1'b0;
         if (state == STOP && scl_rise)
            scl_en <= 1'b0;
         else if (state == ADDR && scl_fall)
            scl_en <= 1'b1;

         case (state)
            IDLE: begin
               if (start) begin
                  rw_q    <= rw;
                  addr_sr <= {addr, rw};
                  data_sr <= wdata;
                  busy    <= 1'b1;
                  ack_err <= 1'b0;
                  rdata   <= '0;
                  state   <= START_WAIT;
               end
            end
            START_WAIT: begin
               if (mid_high) begin
                  sda_oe  <= 1'b1;
                  bit_cnt <= CNT_W'(ADDR_W);
                  state   <= ADDR;
               end
            end
            ADDR: begin
               // Bits change in the low phase; a bit is complete after its high phase.
               if (mid_low) begin
                  sda_oe <= ~addr_sr[ADDR_W];
               end else if (mid_high) begin
                  addr_sr <= addr_sr << 1;
                  if (bit_cnt == '0) state <= ADDR_ACK;
                  else               bit_cnt <= bit_cnt - CNT_W'(1);
               end
            end
            ADDR_ACK: begin
               if (mid_low) begin
                  sda_oe <= 1'b0;
               end else if (mid_high) begin
                  if (sda_in) begin
                     ack_err <= 1'b1;
                     state   <= STOP_LOW;
                  end else begin
                     bit_cnt <= CNT_W'(DATA_W - 1);
                     state   <= DATA;
                  end
               end
            end
            DATA: begin
               if (mid_low) begin
                  sda_oe <= (rw_q == I2C_RW_WRITE) ? ~data_sr[DATA_W-1] : 1'b0;
               end else if (mid_high) begin
                  data_sr <= data_sr << 1;
                  if (rw_q == I2C_RW_READ) rdata <= {rdata[DATA_W-2:0], sda_in};
                  if (bit_cnt == '0) state <= DATA_ACK;
                  else               bit_cnt <= bit_cnt - CNT_W'(1);
               end
            end
            DATA_ACK: begin
               // Releasing here is the slave's ACK window on writes and our NACK on reads.
               if (mid_low) begin
                  sda_oe <= 1'b0;
               end else if (mid_high) begin
                  if (rw_q == I2C_RW_WRITE && sda_in) ack_err <= 1'b1;
                  state <= STOP_LOW;
               end
            end
            STOP_LOW: begin
               if (mid_low) begin
                  sda_oe <= 1'b1;
                  state  <= STOP;
               end
            end
            STOP: begin
               if (mid_high) begin
                  sda_oe <= 1'b0;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
